// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared types and constants for the fetch sequencer
//
// Purpose : FSM state encoding, datapath widths, PC increment, the NOP
//           encoding and the {pc, instr} entry carried by the fetch buffer.
// Ports   : none (package).

package fetch_sequencer_pkg;

   localparam int          INSTR_W  = 32;
   localparam int          PC_W     = 32;
   localparam logic [31:0] PC_INC   = 32'd4;
   localparam logic [31:0] NOP_WORD = 32'h6800_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Branch targets are byte addresses; instructions are word aligned.
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
      return {addr[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - control, instruction memory and decode-side bundle
//
// Purpose : groups every fetch sequencer signal other than clk/rst.
// Ports   : master = the sequencer (drives imem_addr, out_*, busy);
//           slave  = its environment (drives start, halt_req, branch_*,
//           imem_data, out_ready).

interface fetch_sequencer_if;
   import fetch_sequencer_pkg::*;

   logic               start;
   logic               halt_req;
   logic               branch_taken;
   logic [PC_W-1:0]    branch_pc;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_data;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [PC_W-1:0]    out_pc;
   logic               busy;

   modport master (
      input  start, halt_req, branch_taken, branch_pc, imem_data, out_ready,
      output imem_addr, out_valid, out_instr, out_pc, busy
   );

   modport slave (
      output start, halt_req, branch_taken, branch_pc, imem_data, out_ready,
      input  imem_addr, out_valid, out_instr, out_pc, busy
   );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer holding {pc, instr} entries
//
// Purpose : circular buffer of DEPTH entries (power of two) with flush.
// Ports   : clk, rst    - clock, asynchronous active-high reset
//           push, din   - write din when not full (or when popping)
//           pop, dout   - discard head; dout always shows the head slot
//           flush       - empty the buffer, overrides push and pop
//           full, empty, count - occupancy

module fetch_fifo
   import fetch_sequencer_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetch_entry_t             din,
   output fetch_entry_t             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // A full buffer may still accept a write when the head leaves this cycle.
   assign do_push = push & ~flush & (~full | (pop & ~empty));
   assign do_pop  = pop  & ~flush & ~empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Payload storage needs no reset: occupancy alone says what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer top
//
// Purpose : walks the PC through instruction memory, buffering fetched
//           words for the decode stage; supports start, halt with drain,
//           and branch redirect with buffer flush.
// Ports   : clk - clock; rst - asynchronous active-high reset
//           bus - fetch_sequencer_if.master (control inputs, imem
//                 address/data, decode-side valid/ready/instr/pc, busy)

module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter logic [31:0] BOOT_PC   = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   fetch_sequencer_if.master  bus
);

   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

   fetch_state_t     state;
   fetch_state_t     state_next;
   logic [PC_W-1:0]  pc;
   logic [PC_W-1:0]  pc_next;

   logic             push;
   logic             pop;
   logic             flush;
   fetch_entry_t     push_entry;
   fetch_entry_t     head;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   // A transfer to decode happens whenever the head is valid and accepted.
   assign pop = ~fifo_empty & bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         pc    <= BOOT_PC;
      end else begin
         state <= state_next;
         pc    <= pc_next;
      end
   end

   always_comb begin
      state_next       = state;
      pc_next          = pc;
      push             = 1'b0;
      flush            = 1'b0;
      push_entry.pc    = pc;
      push_entry.instr = bus.imem_data;

      case (state)
         ST_IDLE: begin
            // start wins over a simultaneous halt_req; branches are ignored.
            if (bus.start) begin
               state_next = ST_RUN;
               pc_next    = BOOT_PC;
            end
         end

         ST_RUN: begin
            if (bus.branch_taken) begin
               flush   = 1'b1;
               pc_next = align_pc(bus.branch_pc);
            end else if (bus.halt_req) begin
               state_next = ST_DRAIN;
            end else if (~fifo_full | pop) begin
               push    = 1'b1;
               pc_next = pc + PC_INC;
            end
            // Otherwise stalled: PC, and hence imem_addr, hold.
         end

         ST_DRAIN: begin
            if (bus.branch_taken) begin
               flush      = 1'b1;
               pc_next    = align_pc(bus.branch_pc);
               state_next = ST_RUN;
            end else if ((fifo_count == '0) ||
                         ((fifo_count == CNT_W'(1)) && pop)) begin
               state_next = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   fetch_fifo #(
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (push_entry),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bus.imem_addr = pc;
   assign bus.out_valid = ~fifo_empty;
   assign bus.out_instr = fifo_empty ? '0 : head.instr;
   assign bus.out_pc    = fifo_empty ? '0 : head.pc;
   assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer

module tb_fetch_sequencer;
   import fetch_sequencer_pkg::*;

   localparam logic [31:0] BOOT      = 32'h0000_0000;
   localparam logic [31:0] WRAP_BOOT = 32'hFFFF_FFF8;
   localparam int          DEPTH     = 2;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fetch_sequencer_if bus ();
   fetch_sequencer_if bus2 ();

   fetch_sequencer #(.BOOT_PC(BOOT), .BUF_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   fetch_sequencer #(.BOOT_PC(WRAP_BOOT), .BUF_DEPTH(DEPTH)) dut_wrap (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   function automatic logic [31:0] imem_word(input logic [31:0] addr);
      if (addr == 32'h0) return 32'h4C40_0005;
      return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   assign bus.imem_data  = imem_word(bus.imem_addr);
   assign bus2.imem_data = imem_word(bus2.imem_addr);

   // Reference model: a queue of fetched {pc, instr} pairs plus run/drain flags.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        mq[$];
   bit          m_run;
   bit          m_drain;
   logic [31:0] m_pc;
   ent_t        m_tmp;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_run   = 1'b0;
         m_drain = 1'b0;
         m_pc    = BOOT;
         mq.delete();
      end else if (!m_run && !m_drain) begin
         if (bus.start) begin
            m_run = 1'b1;
            m_pc  = BOOT;
         end
      end else if (bus.branch_taken) begin
         mq.delete();
         m_pc    = {bus.branch_pc[31:2], 2'b00};
         m_run   = 1'b1;
         m_drain = 1'b0;
      end else begin
         if (mq.size() > 0 && bus.out_ready) m_tmp = mq.pop_front();
         if (m_run) begin
            if (bus.halt_req) begin
               m_run   = 1'b0;
               m_drain = 1'b1;
            end else if (mq.size() < DEPTH) begin
               mq.push_back('{pc: m_pc, instr: imem_word(m_pc)});
               m_pc = m_pc + 32'd4;
            end
         end else if (mq.size() == 0) begin
            m_drain = 1'b0;
         end
      end
   end

   task automatic clear_inputs();
      bus.start = 0;  bus.halt_req = 0;  bus.branch_taken = 0;
      bus.branch_pc = 0;  bus.out_ready = 0;
      bus2.start = 0; bus2.halt_req = 0; bus2.branch_taken = 0;
      bus2.branch_pc = 0; bus2.out_ready = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.out_instr, bus.out_pc, bus.busy, bus.imem_addr} !==
          {1'b0, 32'h0, 32'h0, 1'b0, BOOT}) begin
         errors++;
         $display("FAIL reset_state: got v=%b i=%h pc=%h busy=%b a=%h, expected all zero and a=%h",
                  bus.out_valid, bus.out_instr, bus.out_pc, bus.busy, bus.imem_addr, BOOT);
      end
      rst = 1'b0;
      bus.branch_taken = 1'b1;
      bus.branch_pc    = 32'h40;
      @(negedge clk);
      bus.branch_taken = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.imem_addr !== BOOT) begin
         errors++;
         $display("FAIL idle_branch_ignored: got busy=%b addr=%h, expected 0 and %h",
                  bus.busy, bus.imem_addr, BOOT);
      end
   endtask

   task automatic test_basic();
      do_reset();
      bus.out_ready = 1'b1;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.imem_addr !== BOOT) begin
         errors++;
         $display("FAIL start_latency: got busy=%b v=%b a=%h, expected 1 0 %h",
                  bus.busy, bus.out_valid, bus.imem_addr, BOOT);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * k) ||
             bus.out_instr !== imem_word(32'(4 * k))) begin
            errors++;
            $display("FAIL stream_%0d: got v=%b pc=%h i=%h, expected 1 %h %h", k,
                     bus.out_valid, bus.out_pc, bus.out_instr, 32'(4 * k), imem_word(32'(4 * k)));
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] got[$];
      do_reset();
      bus.out_ready = 1'b0;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.imem_addr !== 32'h8 ||
          mq.size() != 2) begin
         errors++;
         $display("FAIL stall_hold: got v=%b pc=%h a=%h, expected 1 0 8 (2 held)",
                  bus.out_valid, bus.out_pc, bus.imem_addr);
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10 && got.size() < 3; i++) begin
         if (bus.out_valid) got.push_back(bus.out_pc);
         @(negedge clk);
      end
      checks++;
      if (got.size() != 3) begin
         errors++;
         $display("FAIL stall_release_count: got %0d outputs, expected 3", got.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== 32'(4 * i)) begin
               errors++;
               $display("FAIL stall_release_%0d: got pc %h, expected %h", i, got[i], 32'(4 * i));
            end
         end
      end
   endtask

   task automatic test_branch();
      do_reset();
      bus.out_ready = 1'b0;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      bus.branch_taken = 1'b1;
      bus.branch_pc    = 32'h13;
      bus.halt_req     = 1'b1;
      @(negedge clk);
      bus.branch_taken = 1'b0;
      bus.halt_req     = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h10 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL branch_flush: got v=%b a=%h busy=%b, expected 0 10 1",
                  bus.out_valid, bus.imem_addr, bus.busy);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h10 || bus.out_instr !== imem_word(32'h10)) begin
         errors++;
         $display("FAIL branch_target: got v=%b pc=%h i=%h, expected 1 10 %h",
                  bus.out_valid, bus.out_pc, bus.out_instr, imem_word(32'h10));
      end
   endtask

   task automatic test_halt();
      int transfers;
      do_reset();
      bus.out_ready = 1'b0;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      bus.halt_req  = 1'b1;
      bus.out_ready = 1'b1;
      transfers = bus.out_valid ? 1 : 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bus.halt_req = 1'b0;
         if (!bus.busy) break;
         if (bus.out_valid) transfers++;
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL halt_busy: busy still %b after 8 cycles, expected 0", bus.busy);
      end
      checks++;
      if (transfers != 2) begin
         errors++;
         $display("FAIL halt_drain_count: got %0d outputs, expected 2", transfers);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (bus.imem_addr !== 32'h8 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL halt_idle: got a=%h v=%b busy=%b, expected 8 0 0",
                  bus.imem_addr, bus.out_valid, bus.busy);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc [3];
      logic [31:0] got[$];
      exp_pc[0] = 32'hFFFF_FFF8;
      exp_pc[1] = 32'hFFFF_FFFC;
      exp_pc[2] = 32'h0000_0000;
      do_reset();
      checks++;
      if (bus2.imem_addr !== WRAP_BOOT) begin
         errors++;
         $display("FAIL wrap_reset_addr: got %h, expected %h", bus2.imem_addr, WRAP_BOOT);
      end
      bus2.out_ready = 1'b1;
      bus2.start     = 1'b1;
      @(negedge clk);
      bus2.start = 1'b0;
      for (int i = 0; i < 10 && got.size() < 3; i++) begin
         @(negedge clk);
         if (bus2.out_valid) got.push_back(bus2.out_pc);
      end
      checks++;
      if (got.size() != 3) begin
         errors++;
         $display("FAIL wrap_count: got %0d outputs, expected 3", got.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== exp_pc[i]) begin
               errors++;
               $display("FAIL wrap_pc_%0d: got %h, expected %h", i, got[i], exp_pc[i]);
            end
         end
      end
      bus2.out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [97:0] obs;
      logic [97:0] exp;
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         bus.start        = (!m_run && !m_drain) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
         bus.halt_req     = ($urandom_range(0, 24) == 0);
         bus.branch_taken = ($urandom_range(0, 19) == 0);
         bus.branch_pc    = $urandom;
         bus.out_ready    = ($urandom_range(0, 9) < 6);
         @(negedge clk);
         obs = {bus.out_valid, bus.out_instr, bus.out_pc, bus.busy, bus.imem_addr};
         exp = {mq.size() != 0,
                (mq.size() != 0) ? mq[0].instr : 32'h0,
                (mq.size() != 0) ? mq[0].pc : 32'h0,
                m_run || m_drain,
                m_pc};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL random_cycle_%0d: got v/i/pc/busy/a=%h, expected %h", cyc, obs, exp);
         end
      end
      clear_inputs();
   endtask

   task automatic test_async_reset();
      do_reset();
      bus.out_ready = 1'b1;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.imem_addr !== 32'hC) begin
         errors++;
         $display("FAIL async_pre: got v=%b a=%h, expected 1 c", bus.out_valid, bus.imem_addr);
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.out_valid, bus.out_instr, bus.out_pc, bus.busy, bus.imem_addr} !==
          {1'b0, 32'h0, 32'h0, 1'b0, BOOT}) begin
         errors++;
         $display("FAIL async_reset: got v=%b i=%h pc=%h busy=%b a=%h, expected zeros and a=%h",
                  bus.out_valid, bus.out_instr, bus.out_pc, bus.busy, bus.imem_addr, BOOT);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL async_after: got v=%b busy=%b, expected 0 0", bus.out_valid, bus.busy);
      end
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_basic();
      test_stall();
      test_branch();
      test_halt();
      test_wrap();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001: Parameter BOOT_PC, default 32'h0000_0000, PC loaded on reset and on start.
REQ-002: Parameter BUF_DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-003: clk  input  1  sole clock, all state updates on posedge.
REQ-004: rst  input  1  asynchronous, active-high reset.
REQ-005: start  input  1  begin fetching from BOOT_PC when in IDLE.
REQ-006: halt_req  input  1  stop fetching, drain buffer, return to IDLE.
REQ-007: branch_taken  input  1  redirect fetch to branch_pc, discard buffered instructions.
REQ-008: branch_pc  input  32  redirect target byte address.
REQ-009: imem_addr  output  32  byte address to instruction memory (equals current PC).
REQ-010: imem_data  input  32  instruction word, combinational read of imem_addr in the same cycle.
REQ-011: out_valid  output  1  buffer head holds a valid instruction.
REQ-012: out_ready  input  1  decode stage accepts head this cycle.
REQ-013: out_instr  output  32  head instruction word; 32'h0 when out_valid=0.
REQ-014: out_pc  output  32  PC of head instruction; 32'h0 when out_valid=0.
REQ-015: busy  output  1  high in RUN or DRAIN.

Function
REQ-016: FSM states IDLE, RUN, DRAIN; reset state IDLE.
REQ-017: IDLE -> RUN when start=1; PC <= BOOT_PC; no push that cycle.
REQ-018: RUN -> DRAIN when halt_req=1 (no branch); no push that cycle.
REQ-019: DRAIN -> IDLE in the cycle the buffer becomes empty (count 0 after pop); entered-empty DRAIN exits next cycle.
REQ-020: Push in RUN when (count < BUF_DEPTH) or (out_valid & out_ready); push writes {PC, imem_data}, PC <= PC + 4.
REQ-021: No push and PC held when buffer full and not popping (stall); imem_addr stays stable.
REQ-022: Pop when out_valid & out_ready; simultaneous push and pop leaves count unchanged.
REQ-023: branch_taken in RUN or DRAIN has highest priority: buffer flushed (count 0), no push, PC <= {branch_pc[31:2],2'b00}, state RUN (overrides halt_req).
REQ-024: branch_taken in IDLE ignored.
REQ-025: out_valid/out_instr/out_pc are registered-buffer outputs: first push visible one cycle after the push edge.
REQ-026: PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0.
REQ-027: start ignored outside IDLE; start and halt_req both high in IDLE -> RUN.

Reset
REQ-028: rst=1 immediately forces IDLE, PC=BOOT_PC, count=0, out_valid=0, out_instr=0, out_pc=0, busy=0, imem_addr=BOOT_PC.
REQ-029: Reset mid-operation discards all buffered instructions; no output transfer completes on the reset edge.

Structure
REQ-030: Shared package holds FSM state encoding, INSTR_W=32, PC_INC=4, NOP word 32'h6800_0000.
REQ-031: Buffer is sub-module fetch_fifo (push, pop, flush, full, empty, {pc,instr} payload); FSM and PC in top.

Verification
REQ-032: Reset, start, imem word 0 = 32'h4C40_0005, out_ready=1 -> out_valid one cycle later with out_instr=32'h4C40_0005, out_pc=0, then out_pc 4, 8 each cycle.
REQ-033: out_ready=0 for 5 cycles after start -> exactly 2 entries held (pc 0, 4), imem_addr frozen at 8; release -> pc 0,4,8 in order, no loss or duplicate.
REQ-034: branch_taken with branch_pc=32'h13 while 2 entries buffered -> out_valid=0 next cycle, next output out_pc=32'h10.
REQ-035: halt_req with 2 entries and out_ready=1 -> 2 more outputs, busy falls, state IDLE, imem_addr unchanged thereafter.
REQ-036: BOOT_PC=32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037: rst asserted asynchronously between edges mid-RUN -> out_valid=0 and imem_addr=BOOT_PC before next edge.
